// File: rtl/decimal_to_binary.sv
// ---------------------------------------------------------------------------
// decimal_to_binary
//
// Purpose:
//    Sequential BCD-to-binary converter. It is the inverse of the scope's
//    binary-to-decimal display path. A packed N_DIGITS BCD value, typically
//    typed in for the trigger level, offset or timebase, becomes a binary
//    word plus an ADC-range code. The trigger and measurement logic compares
//    that code against raw ADC samples.
//
//    The conversion is iterative and handles one digit per clock, most
//    significant digit first. The handshake is start/busy/done.
//
// Ports:
//    clk      in   1            system clock, rising edge
//    rst      in   1            synchronous reset, active-low
//    start    in   1            conversion request, only looked at in IDLE
//    bcd_in   in   4*N_DIGITS   packed BCD, most significant digit on top
//    busy     out  1            conversion in progress
//    done     out  1            one-cycle pulse, results valid from here on
//    bin_out  out  OUT_W        binary value of the captured BCD
//    adc_code out  ADC_W        ADC-range code derived from bin_out
//    ovf      out  1            bin_out above the ADC full-scale code
//    err      out  1            captured input had a nibble greater than 9
//
// Configuration:
//    DEC2BIN_SAT_EN  When defined, adc_code saturates at 2^ADC_W-1 and ovf
//                    flags the clip. When undefined, adc_code is a plain
//                    truncation of bin_out and ovf is tied low.
// ---------------------------------------------------------------------------
module decimal_to_binary #(
   parameter int N_DIGITS = 6,
   parameter int OUT_W    = 20,
   parameter int ADC_W    = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*N_DIGITS-1:0] bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [OUT_W-1:0]      bin_out,
   output logic [ADC_W-1:0]      adc_code,
   output logic                  ovf,
   output logic                  err
);

   localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N_DIGITS - 1);

   typedef enum logic {
      IDLE,
      CONV
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [4*N_DIGITS-1:0] digits_q;
   logic [OUT_W-1:0]      acc_q;
   logic [OUT_W-1:0]      acc_d;
   logic [CNT_W-1:0]      cnt_q;
   logic                  errPend_q;
   logic                  errNext;
   logic                  lastDigit;
   logic                  done_q;
   logic [OUT_W-1:0]      binOut_q;
   logic [ADC_W-1:0]      adcCode_q;
   logic [ADC_W-1:0]      adcCode_d;
   logic                  err_q;

   // Accept a request in IDLE. Leave CONV once the last digit has been
   // folded in, so the accumulation spends exactly N_DIGITS cycles in CONV.
   assign lastDigit = (cnt_q == LAST_DIGIT);

   // State register. Reset dominates a start on the same edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A start seen while converting is dropped, not queued.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CONV;
         CONV:    if (lastDigit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic. busy follows the state directly, so it falls on the same
   // edge that raises the registered done pulse.
   always_comb begin
      busy = (state_q == CONV);
      done = done_q;
   end

   // Flag any nibble that is not a decimal digit. The check runs on the live
   // input and is kept only at the accepting edge.
   always_comb begin
      errNext = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) errNext = 1'b1;
      end
   end

   // One Horner step: acc*10 + top digit, with *10 built as (acc<<3)+(acc<<1).
   // OUT_W is chosen large enough that legal inputs never truncate.
   always_comb begin
      acc_d = (acc_q << 3) + (acc_q << 1)
            + {{(OUT_W-4){1'b0}}, digits_q[4*N_DIGITS-1 -: 4]};
   end

`ifdef DEC2BIN_SAT_EN
   localparam logic [OUT_W-1:0] ADC_MAX = OUT_W'((2 ** ADC_W) - 1);

   logic ovf_q;
   logic ovf_d;

   // Clip the final sum to the ADC full-scale code and remember that we did.
   always_comb begin
      ovf_d     = (acc_d > ADC_MAX);
      adcCode_d = ovf_d ? {ADC_W{1'b1}} : acc_d[ADC_W-1:0];
   end

   // The overflow flag is registered together with bin_out. It is forced
   // low when the captured input was not valid BCD.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else if (state_q == CONV && lastDigit) begin
         ovf_q <= errPend_q ? 1'b0 : ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   // Without saturation the code is simply the low bits of the result.
   always_comb begin
      adcCode_d = acc_d[ADC_W-1:0];
   end

   assign ovf = 1'b0;
`endif

   // Datapath. In IDLE it captures a request. In CONV it walks the digits.
   // On the last digit it publishes the result, or zeros plus err when the
   // input held a non-decimal nibble. Results then hold until the next done.
   always_ff @(posedge clk) begin
      if (!rst) begin
         digits_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         errPend_q <= 1'b0;
         done_q    <= 1'b0;
         binOut_q  <= '0;
         adcCode_q <= '0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  digits_q  <= bcd_in;
                  acc_q     <= '0;
                  cnt_q     <= '0;
                  errPend_q <= errNext;
               end
            end
            CONV: begin
               acc_q    <= acc_d;
               digits_q <= digits_q << 4;
               cnt_q    <= cnt_q + 1'b1;
               if (lastDigit) begin
                  done_q <= 1'b1;
                  err_q  <= errPend_q;
                  if (errPend_q) begin
                     binOut_q  <= '0;
                     adcCode_q <= '0;
                  end else begin
                     binOut_q  <= acc_d;
                     adcCode_q <= adcCode_d;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bin_out  = binOut_q;
   assign adc_code = adcCode_q;
   assign err      = err_q;

endmodule
